// File: rtl/fetch_ctl.sv
// rtl/fetch_ctl.sv - single-outstanding instruction fetch controller with kill tracking and a one-entry skid
module fetch_ctl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    input  logic        redirect,
    output logic        ic_req,
    input  logic        ic_rdy,
    output logic [63:0] ic_addr,
    input  logic        ic_vld,
    input  logic [31:0] ic_data,
    output logic        pc_stall,
    output logic        if_vld,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        dec_stall,
    output logic [15:0] kill_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        kill;
    logic [63:0] req_pc;
    logic [31:0] skid_instr;
    logic [63:0] skid_pc;

    logic out_free;
    logic rsp_kill;
    logic rsp_load;
    logic rsp_skid;
    logic hold_kill;
    logic hold_drain;

    always_comb begin
        out_free   = !if_vld || !dec_stall;
        rsp_kill   = (state == S_WAIT) && ic_vld && (kill || redirect);
        rsp_load   = (state == S_WAIT) && ic_vld && !kill && !redirect && out_free;
        rsp_skid   = (state == S_WAIT) && ic_vld && !kill && !redirect && !out_free;
        hold_kill  = (state == S_HOLD) && redirect;
        hold_drain = (state == S_HOLD) && !redirect && !dec_stall;
    end

    always_comb begin
        ic_req  = (state == S_REQ) && !redirect;
        ic_addr = (state == S_REQ) ? pc : 64'd0;
        // The PC may only move on a redirect or when an instruction leaves for decode.
        pc_stall = !(((state == S_REQ) && redirect) ||
                     ((state == S_WAIT) && redirect) ||
                     rsp_load || hold_drain || hold_kill);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  if (ic_req && ic_rdy) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rsp_kill || rsp_load) state_nxt = S_REQ;
                else if (rsp_skid)        state_nxt = S_HOLD;
            end
            S_HOLD: if (hold_kill || hold_drain) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            kill       <= 1'b0;
            req_pc     <= 64'd0;
            skid_instr <= NOP;
            skid_pc    <= 64'd0;
            if_vld     <= 1'b0;
            if_instr   <= NOP;
            if_pc      <= 64'd0;
            kill_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;

            if (ic_req && ic_rdy)
                req_pc <= pc;

            // A redirect with no response yet poisons the one outstanding fetch.
            if (rsp_kill)
                kill <= 1'b0;
            else if ((state == S_WAIT) && redirect)
                kill <= 1'b1;

            if (rsp_skid) begin
                skid_instr <= ic_data;
                skid_pc    <= req_pc;
            end else if (hold_kill) begin
                skid_instr <= NOP;
                skid_pc    <= 64'd0;
            end

            if (rsp_load) begin
                if_vld   <= 1'b1;
                if_instr <= ic_data;
                if_pc    <= req_pc;
            end else if (hold_kill) begin
                if_vld <= 1'b0;
            end else if (hold_drain) begin
                if_vld   <= 1'b1;
                if_instr <= skid_instr;
                if_pc    <= skid_pc;
            end else if (redirect && if_vld) begin
                if_vld <= 1'b0;
            end else if (if_vld && !dec_stall) begin
                if_vld <= 1'b0;
            end

            if ((rsp_kill || hold_kill) && (kill_cnt != 16'hFFFF))
                kill_cnt <= kill_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_ctl.sv
// tb/tb_fetch_ctl.sv - table-driven cycle vectors with a delivery scoreboard for fetch_ctl
module tb_fetch_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc;
    logic        redirect;
    logic        ic_req;
    logic        ic_rdy;
    logic [63:0] ic_addr;
    logic        ic_vld;
    logic [31:0] ic_data;
    logic        pc_stall;
    logic        if_vld;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        dec_stall;
    logic [15:0] kill_cnt;

    fetch_ctl dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .redirect(redirect),
        .ic_req(ic_req), .ic_rdy(ic_rdy), .ic_addr(ic_addr),
        .ic_vld(ic_vld), .ic_data(ic_data), .pc_stall(pc_stall),
        .if_vld(if_vld), .if_instr(if_instr), .if_pc(if_pc),
        .dec_stall(dec_stall), .kill_cnt(kill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redirect;
        logic        ic_rdy;
        logic        ic_vld;
        logic [31:0] data;
        logic        dec_stall;
        logic [63:0] pc;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_stall;
        logic        exp_ifvld;
        logic [15:0] exp_cnt;
        logic        push;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } sb_t;

    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_req_pc = 64'd0;

    localparam logic [63:0] A  = 64'h8000_0000;
    localparam logic [63:0] C0 = 64'h8000_1000;
    localparam logic [31:0] D1 = 32'h0050_0093;
    localparam logic [31:0] D2 = 32'h00a0_0113;
    localparam logic [31:0] D3 = 32'h0020_8193;
    localparam logic [31:0] D4 = 32'h0031_0213;
    localparam logic [31:0] DX = 32'hdead_beef;
    localparam logic [31:0] D7 = 32'h0000_0517;

    function automatic vec_t mk(input logic r, input logic rdy, input logic vld,
                                input logic [31:0] d, input logic ds, input logic [63:0] p,
                                input logic er, input logic [63:0] ea, input logic es,
                                input logic eiv, input logic [15:0] ec, input logic pu);
        vec_t v;
        v.redirect = r;   v.ic_rdy = rdy;    v.ic_vld = vld;     v.data = d;
        v.dec_stall = ds; v.pc = p;          v.exp_req = er;     v.exp_addr = ea;
        v.exp_stall = es; v.exp_ifvld = eiv; v.exp_cnt = ec;     v.push = pu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " ic_req"},   64'(ic_req),   64'd0);
        chk({tag, " ic_addr"},  ic_addr,       64'd0);
        chk({tag, " pc_stall"}, 64'(pc_stall), 64'd1);
        chk({tag, " if_vld"},   64'(if_vld),   64'd0);
        chk({tag, " if_instr"}, 64'(if_instr), 64'h13);
        chk({tag, " if_pc"},    if_pc,         64'd0);
        chk({tag, " kill_cnt"}, 64'(kill_cnt), 64'd0);
    endtask

    // Called just after a rising edge; checks at the falling edge, returns just after the next rising edge.
    task automatic apply(input vec_t v, input string tag);
        sb_t e;
        redirect = v.redirect; ic_rdy = v.ic_rdy; ic_vld = v.ic_vld;
        ic_data = v.data; dec_stall = v.dec_stall; pc = v.pc;
        @(negedge clk);
        chk({tag, " ic_req"},   64'(ic_req),   64'(v.exp_req));
        chk({tag, " ic_addr"},  ic_addr,       v.exp_addr);
        chk({tag, " pc_stall"}, 64'(pc_stall), 64'(v.exp_stall));
        chk({tag, " if_vld"},   64'(if_vld),   64'(v.exp_ifvld));
        chk({tag, " kill_cnt"}, 64'(kill_cnt), 64'(v.exp_cnt));
        if (if_vld && !dec_stall) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL %s unexpected delivery: got %h@%h expected none", tag, if_instr, if_pc);
            end else begin
                e = sb.pop_front();
                chk({tag, " if_instr"}, 64'(if_instr), 64'(e.instr));
                chk({tag, " if_pc"},    if_pc,         e.pc);
            end
        end
        if (v.push) begin
            e.instr = v.data; e.pc = last_req_pc;
            sb.push_back(e);
        end
        if (v.exp_req && v.ic_rdy) last_req_pc = v.pc;
        @(posedge clk); #1;
    endtask

    vec_t tbl[16];
    vec_t kseq[11];
    vec_t rseq[6];
    vec_t sseq[6];

    initial begin
        // basic fetch, backpressure through HOLD, redirect in REQ, wrong-path clear at decode
        tbl[0]  = mk(0,1,0,0,0,A,          0,0,1,0,0,0);
        tbl[1]  = mk(0,1,0,0,0,A,          1,A,1,0,0,0);
        tbl[2]  = mk(0,1,0,0,0,A,          0,0,1,0,0,0);
        tbl[3]  = mk(0,1,1,D1,0,A,         0,0,0,0,0,1);
        tbl[4]  = mk(0,1,0,0,0,A+4,        1,A+4,1,1,0,0);
        tbl[5]  = mk(0,1,1,D2,0,A+4,       0,0,0,0,0,1);
        tbl[6]  = mk(0,1,0,0,1,A+8,        1,A+8,1,1,0,0);
        tbl[7]  = mk(0,1,1,D3,1,A+8,       0,0,1,1,0,1);
        tbl[8]  = mk(0,1,0,0,1,A+8,        0,0,1,1,0,0);
        tbl[9]  = mk(0,1,0,0,0,A+8,        0,0,0,1,0,0);
        tbl[10] = mk(0,1,0,0,0,A+12,       1,A+12,1,1,0,0);
        tbl[11] = mk(0,1,0,0,0,A+12,       0,0,1,0,0,0);
        tbl[12] = mk(0,1,1,D4,0,A+12,      0,0,0,0,0,0);
        tbl[13] = mk(1,1,0,0,1,A+16,       0,A+16,0,1,0,0);
        tbl[14] = mk(0,1,0,0,0,A+'h100,    1,A+'h100,1,0,0,0);
        tbl[15] = mk(0,1,0,0,0,A+'h100,    0,0,1,0,0,0);

        // kill in WAIT, redirect coincident with response, redirect while in HOLD
        kseq[0]  = mk(1,1,0,0,0,A+'h100,   0,0,0,0,0,0);
        kseq[1]  = mk(0,1,1,DX,0,A+'h200,  0,0,1,0,0,0);
        kseq[2]  = mk(0,1,0,0,0,A+'h200,   1,A+'h200,1,0,1,0);
        kseq[3]  = mk(1,1,1,DX,0,A+'h200,  0,0,0,0,1,0);
        kseq[4]  = mk(0,1,0,0,0,A+'h300,   1,A+'h300,1,0,2,0);
        kseq[5]  = mk(0,1,1,DX,0,A+'h300,  0,0,0,0,2,0);
        kseq[6]  = mk(0,1,0,0,1,A+'h304,   1,A+'h304,1,1,2,0);
        kseq[7]  = mk(0,1,1,DX,1,A+'h304,  0,0,1,1,2,0);
        kseq[8]  = mk(1,1,0,0,1,A+'h304,   0,0,0,1,2,0);
        kseq[9]  = mk(0,1,0,0,0,A+'h400,   1,A+'h400,1,0,3,0);
        kseq[10] = mk(0,1,0,0,0,A+'h400,   0,0,1,0,3,0);

        // after a reset mid-WAIT: stale response ignored, one fresh fetch
        rseq[0] = mk(0,1,1,DX,0,C0,        0,0,1,0,0,0);
        rseq[1] = mk(0,0,1,DX,0,C0,        1,C0,1,0,0,0);
        rseq[2] = mk(0,1,0,0,0,C0,         1,C0,1,0,0,0);
        rseq[3] = mk(0,1,1,D7,0,C0,        0,0,0,0,0,1);
        rseq[4] = mk(0,1,0,0,0,C0+4,       1,C0+4,1,1,0,0);
        rseq[5] = mk(0,1,0,0,0,C0+4,       0,0,1,0,0,0);

        // saturation from a preloaded 16'hFFFE
        sseq[0] = mk(1,1,1,DX,0,C0+4,      0,0,0,0,16'hFFFE,0);
        sseq[1] = mk(0,1,0,0,0,C0+8,       1,C0+8,1,0,16'hFFFF,0);
        sseq[2] = mk(1,1,1,DX,0,C0+8,      0,0,0,0,16'hFFFF,0);
        sseq[3] = mk(0,1,0,0,0,C0+12,      1,C0+12,1,0,16'hFFFF,0);
        sseq[4] = mk(1,1,1,DX,0,C0+12,     0,0,0,0,16'hFFFF,0);
        sseq[5] = mk(0,1,0,0,0,C0+16,      1,C0+16,1,0,16'hFFFF,0);

        rst_n = 1'b0; pc = A; redirect = 1'b0; ic_rdy = 1'b0;
        ic_vld = 1'b0; ic_data = 32'd0; dec_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 11; i++) apply(kseq[i], $sformatf("kill%0d", i));

        // state is WAIT with a request outstanding; reset and leave a stale response on the bus
        apply(mk(0,1,0,0,0,A+'h400, 0,0,1,0,3,0), "prerst");
        rst_n = 1'b0; ic_vld = 1'b1; ic_data = DX;
        #1;
        check_reset("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) apply(rseq[i], $sformatf("rst%0d", i));

        force dut.kill_cnt = 16'hFFFE;
        #1;
        release dut.kill_cnt;
        for (int i = 0; i < 6; i++) apply(sseq[i], $sformatf("sat%0d", i));

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
